// File: rtl/seg_scan_driver.sv
// +----------------------------------------------------------------------------+
// | seg_scan_driver: 4-digit multiplexed 7-segment driver, frame-atomic update  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_driver #(
  parameter bit LZB = 1'b1
) (
  input  logic        c,
  input  logic        rst,
  input  logic [3:0]  ring,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        err
);

  localparam logic [6:0] C_BLANK = 7'h7F;

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q,  pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic [15:0] shad_val_q, shad_val_d;
  logic [3:0]  shad_dp_q,  shad_dp_d;
  logic        err_q, err_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        w_commit;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [3:0]  w_nib;
  logic [3:0]  w_lead_zero;
  logic        w_blank;
  logic [6:0]  w_enc;

  always_comb begin
    w_commit    = (ring == 4'b1000) && pend_flag_q;
    pend_val_d  = load ? data  : pend_val_q;
    pend_dp_d   = load ? dp_in : pend_dp_q;
    pend_flag_d = load || (pend_flag_q && !w_commit);
    shad_val_d  = w_commit ? pend_val_q : shad_val_q;
    shad_dp_d   = w_commit ? pend_dp_q  : shad_dp_q;
  end

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (ring)
      4'b1000: w_idx = 2'd3;
      4'b0100: w_idx = 2'd2;
      4'b0010: w_idx = 2'd1;
      4'b0001: w_idx = 2'd0;
      default: w_onehot = 1'b0;
    endcase
  end

  // The frame being scanned out uses the just-committed value at frame start,
  // so digit 3 of a new frame never shows stale contents.
  always_comb begin
    w_nib          = shad_val_d[{w_idx, 2'b00} +: 4];
    w_lead_zero[3] = (shad_val_d[15:12] == 4'h0);
    w_lead_zero[2] = w_lead_zero[3] && (shad_val_d[11:8] == 4'h0);
    w_lead_zero[1] = w_lead_zero[2] && (shad_val_d[7:4] == 4'h0);
    w_lead_zero[0] = 1'b0;
    w_blank        = LZB && w_lead_zero[w_idx];
  end

  always_comb begin
    case (w_nib)
      4'h0: w_enc = 7'h40;
      4'h1: w_enc = 7'h79;
      4'h2: w_enc = 7'h24;
      4'h3: w_enc = 7'h30;
      4'h4: w_enc = 7'h19;
      4'h5: w_enc = 7'h12;
      4'h6: w_enc = 7'h02;
      4'h7: w_enc = 7'h78;
      4'h8: w_enc = 7'h00;
      4'h9: w_enc = 7'h10;
      4'hA: w_enc = 7'h08;
      4'hB: w_enc = 7'h03;
      4'hC: w_enc = 7'h46;
      4'hD: w_enc = 7'h21;
      4'hE: w_enc = 7'h06;
      default: w_enc = 7'h0E;
    endcase
  end

  always_comb begin
    err_d = err_q || !w_onehot;
    if (w_onehot) begin
      an_d  = ~ring;
      seg_d = w_blank ? C_BLANK : w_enc;
      dp_d  = ~shad_dp_d[w_idx];
    end else begin
      an_d  = 4'hF;
      seg_d = C_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      pend_val_q  <= 16'h0000;
      pend_dp_q   <= 4'h0;
      pend_flag_q <= 1'b0;
      shad_val_q  <= 16'h0000;
      shad_dp_q   <= 4'h0;
      err_q       <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= C_BLANK;
      dp_q        <= 1'b1;
    end else begin
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      shad_val_q  <= shad_val_d;
      shad_dp_q   <= shad_dp_d;
      err_q       <= err_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = pend_flag_q;
  assign err  = err_q;

endmodule

`default_nettype wire
